mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one memory-controller port among icache fetch, load/store and
// next-line prefetch, with a starvation guard for fetch and flush cancellation.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_data,
  input  logic        lsu_req,
  input  logic        lsu_rw,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [1:0]  lsu_type,
  output logic        lsu_ack,
  output logic [31:0] lsu_rdata,
  input  logic        pf_req,
  input  logic [31:0] pf_addr,
  output logic        pf_ack,
  output logic [31:0] pf_data,
  input  logic        flush,
  output logic        mc_valid,
  output logic        mc_rw,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_wdata,
  output logic [1:0]  mc_type,
  input  logic        mc_done,
  input  logic [31:0] mc_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_LSU  = 2'd2;
  localparam logic [1:0] OWN_PF   = 2'd3;

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [1:0]    state_reg;
  logic [1:0]    owner_reg;
  logic [CW-1:0] starve_cnt_reg;
  logic [1:0]    grant;
  logic          cancelable;
  logic [31:0]   load_data;

  // Fetch jumps ahead of LSU only once it has been starved for STARVE_LIMIT grants.
  always_comb begin
    grant = OWN_NONE;
    if (state_reg == IDLE) begin
      if (if_req && !flush && starve_cnt_reg == LIMIT) grant = OWN_IF;
      else if (lsu_req)                                grant = OWN_LSU;
      else if (if_req && !flush)                       grant = OWN_IF;
      else if (pf_req && !flush)                       grant = OWN_PF;
    end
  end

  assign cancelable = (owner_reg == OWN_IF) || (owner_reg == OWN_PF);

  always_comb begin
    load_data = mc_rdata;
    case (mc_type)
      2'b01:   load_data = {24'd0, mc_rdata[7:0]};
      2'b10:   load_data = {16'd0, mc_rdata[15:0]};
      default: load_data = mc_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_NONE;
      starve_cnt_reg <= '0;
      if_ack         <= 1'b0;
      if_data        <= '0;
      lsu_ack        <= 1'b0;
      lsu_rdata      <= '0;
      pf_ack         <= 1'b0;
      pf_data        <= '0;
      mc_valid       <= 1'b0;
      mc_rw          <= 1'b0;
      mc_addr        <= '0;
      mc_wdata       <= '0;
      mc_type        <= '0;
    end else begin
      if_ack  <= 1'b0;
      lsu_ack <= 1'b0;
      pf_ack  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant == OWN_LSU) begin
            if (!if_req)                     starve_cnt_reg <= '0;
            else if (starve_cnt_reg != LIMIT) starve_cnt_reg <= starve_cnt_reg + CW'(1);
          end else if (grant == OWN_IF || !if_req) begin
            starve_cnt_reg <= '0;
          end
          if (grant != OWN_NONE) begin
            owner_reg <= grant;
            state_reg <= BUSY;
            mc_valid  <= 1'b1;
            if (grant == OWN_LSU) begin
              mc_rw    <= lsu_rw;
              mc_addr  <= lsu_addr;
              mc_wdata <= lsu_wdata;
              mc_type  <= lsu_type;
            end else begin
              mc_rw    <= 1'b0;
              mc_addr  <= (grant == OWN_IF) ? if_addr : pf_addr;
              mc_wdata <= '0;
              mc_type  <= 2'b11;
            end
          end
        end
        BUSY: begin
          if (mc_done) begin
            state_reg <= IDLE;
            owner_reg <= OWN_NONE;
            mc_valid  <= 1'b0;
            // A flush landing on the completion cycle still discards fetch data.
            if (!(flush && cancelable)) begin
              case (owner_reg)
                OWN_IF:  begin if_ack  <= 1'b1; if_data   <= mc_rdata;  end
                OWN_LSU: begin lsu_ack <= 1'b1; lsu_rdata <= load_data; end
                OWN_PF:  begin pf_ack  <= 1'b1; pf_data   <= mc_rdata;  end
                default: ;
              endcase
            end
          end else if (flush && cancelable) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (mc_done) begin
            state_reg <= IDLE;
            owner_reg <= OWN_NONE;
            mc_valid  <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios for mem_arbiter; inputs change and outputs are sampled 1ns after posedge.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_data;
  logic        lsu_req;
  logic        lsu_rw;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [1:0]  lsu_type;
  logic        lsu_ack;
  logic [31:0] lsu_rdata;
  logic        pf_req;
  logic [31:0] pf_addr;
  logic        pf_ack;
  logic [31:0] pf_data;
  logic        flush;
  logic        mc_valid;
  logic        mc_rw;
  logic [31:0] mc_addr;
  logic [31:0] mc_wdata;
  logic [1:0]  mc_type;
  logic        mc_done;
  logic [31:0] mc_rdata;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
    .lsu_req(lsu_req), .lsu_rw(lsu_rw), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_type(lsu_type), .lsu_ack(lsu_ack), .lsu_rdata(lsu_rdata),
    .pf_req(pf_req), .pf_addr(pf_addr), .pf_ack(pf_ack), .pf_data(pf_data),
    .flush(flush),
    .mc_valid(mc_valid), .mc_rw(mc_rw), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_type(mc_type), .mc_done(mc_done), .mc_rdata(mc_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 0; if_addr = 0; lsu_req = 0; lsu_rw = 0; lsu_addr = 0;
    lsu_wdata = 0; lsu_type = 0; pf_req = 0; pf_addr = 0; flush = 0; mc_done = 0; mc_rdata = 0;
    tick(); tick();
    checks++; if (mc_valid !== 1'b0) begin errors++; $display("FAIL reset_mc_valid: got %b expected 0", mc_valid); end
    checks++; if ({if_ack, lsu_ack, pf_ack} !== 3'b000) begin errors++; $display("FAIL reset_acks: got %b expected 000", {if_ack, lsu_ack, pf_ack}); end
    checks++; if (mc_addr !== 32'h0 || mc_type !== 2'b00) begin errors++; $display("FAIL reset_mc_regs: got addr %h type %b expected 0", mc_addr, mc_type); end
    rst = 1'b0;
    tick();
    $display("txn reset: outputs cleared");
  endtask

  task automatic test_lsu_read();
    lsu_req = 1; lsu_rw = 0; lsu_addr = 32'h1000; lsu_type = 2'b11;
    tick();
    checks++; if (mc_valid !== 1'b1 || mc_addr !== 32'h1000 || mc_rw !== 1'b0) begin errors++; $display("FAIL lsu_read_grant: got valid %b addr %h rw %b expected 1 00001000 0", mc_valid, mc_addr, mc_rw); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (mc_valid !== 1'b1 || lsu_ack !== 1'b0) begin errors++; $display("FAIL lsu_read_hold: got valid %b ack %b expected 1 0", mc_valid, lsu_ack); end
    mc_done = 1; mc_rdata = 32'hDEADBEEF;
    tick();
    mc_done = 0; lsu_req = 0;
    checks++; if (lsu_ack !== 1'b1 || lsu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lsu_read_ack: got ack %b data %h expected 1 deadbeef", lsu_ack, lsu_rdata); end
    checks++; if (mc_valid !== 1'b0) begin errors++; $display("FAIL lsu_read_valid_drop: got %b expected 0", mc_valid); end
    tick();
    checks++; if (lsu_ack !== 1'b0 || lsu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lsu_read_hold_data: got ack %b data %h expected 0 deadbeef", lsu_ack, lsu_rdata); end
    $display("txn lsu_read: addr 00001000 data %h", lsu_rdata);
  endtask

  task automatic test_starvation();
    logic [5:0] exp_if;
    exp_if = 6'b010000;  // bit i set when grant i belongs to IF
    if_req = 1; if_addr = 32'h2000; lsu_req = 1; lsu_addr = 32'h4000; lsu_rw = 0; lsu_type = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (mc_valid !== 1'b1 || mc_addr !== (exp_if[i] ? 32'h2000 : 32'h4000)) begin errors++; $display("FAIL starve_grant%0d: got valid %b addr %h expected 1 %h", i, mc_valid, mc_addr, exp_if[i] ? 32'h2000 : 32'h4000); end
      mc_done = 1; mc_rdata = 32'h100 + i;
      tick();
      mc_done = 0;
      checks++; if (if_ack !== exp_if[i] || lsu_ack !== !exp_if[i] || pf_ack !== 1'b0) begin errors++; $display("FAIL starve_ack%0d: got if %b lsu %b pf %b expected if %b lsu %b pf 0", i, if_ack, lsu_ack, pf_ack, exp_if[i], !exp_if[i]); end
      if (exp_if[i]) if_req = 0;
      if (i == 5) lsu_req = 0;
      $display("txn starve %0d: addr %h if_ack %b lsu_ack %b", i, mc_addr, if_ack, lsu_ack);
    end
    tick();
  endtask

  task automatic test_flush_if();
    if_req = 1; if_addr = 32'h2000;
    tick();
    checks++; if (mc_valid !== 1'b1 || mc_addr !== 32'h2000 || mc_type !== 2'b11) begin errors++; $display("FAIL flush_if_grant: got valid %b addr %h type %b expected 1 00002000 11", mc_valid, mc_addr, mc_type); end
    tick();
    flush = 1;
    tick();
    flush = 0; if_req = 0;
    tick(); tick();
    checks++; if (mc_valid !== 1'b1 || mc_addr !== 32'h2000 || if_ack !== 1'b0) begin errors++; $display("FAIL flush_if_drain: got valid %b addr %h ack %b expected 1 00002000 0", mc_valid, mc_addr, if_ack); end
    mc_done = 1; mc_rdata = 32'h11112222;
    tick();
    mc_done = 0;
    checks++; if (if_ack !== 1'b0 || mc_valid !== 1'b0) begin errors++; $display("FAIL flush_if_noack: got ack %b valid %b expected 0 0", if_ack, mc_valid); end
    tick();
    checks++; if (if_ack !== 1'b0 || mc_valid !== 1'b0) begin errors++; $display("FAIL flush_if_after: got ack %b valid %b expected 0 0", if_ack, mc_valid); end
    $display("txn flush_if: addr 00002000 drained, if_ack suppressed");
  endtask

  task automatic test_flush_blocks_idle();
    if_req = 1; if_addr = 32'h2100; flush = 1;
    tick();
    flush = 0;
    checks++; if (mc_valid !== 1'b0) begin errors++; $display("FAIL flush_block_if: got valid %b expected 0", mc_valid); end
    tick();
    checks++; if (mc_valid !== 1'b1 || mc_addr !== 32'h2100) begin errors++; $display("FAIL flush_release_if: got valid %b addr %h expected 1 00002100", mc_valid, mc_addr); end
    mc_done = 1; mc_rdata = 32'h0BADF00D;
    tick();
    mc_done = 0; if_req = 0;
    checks++; if (if_ack !== 1'b1 || if_data !== 32'h0BADF00D) begin errors++; $display("FAIL flush_release_ack: got ack %b data %h expected 1 0badf00d", if_ack, if_data); end
    tick();
    $display("txn flush_block: if grant delayed one cycle, data %h", if_data);
  endtask

  task automatic test_lsu_store_flush();
    lsu_req = 1; lsu_rw = 1; lsu_type = 2'b01; lsu_wdata = 32'h000000AB; lsu_addr = 32'h30004;
    tick();
    checks++; if (mc_valid !== 1'b1 || mc_rw !== 1'b1 || mc_type !== 2'b01 || mc_wdata !== 32'hAB || mc_addr !== 32'h30004) begin errors++; $display("FAIL store_grant: got v%b rw%b t%b wd %h a %h expected v1 rw1 t01 wd 000000ab a 00030004", mc_valid, mc_rw, mc_type, mc_wdata, mc_addr); end
    lsu_wdata = 32'hFFFFFFFF; lsu_addr = 32'h0; lsu_type = 2'b11; flush = 1;
    tick();
    flush = 0;
    tick();
    checks++; if (mc_valid !== 1'b1 || mc_rw !== 1'b1 || mc_type !== 2'b01 || mc_wdata !== 32'hAB || mc_addr !== 32'h30004) begin errors++; $display("FAIL store_stable: got v%b rw%b t%b wd %h a %h expected v1 rw1 t01 wd 000000ab a 00030004", mc_valid, mc_rw, mc_type, mc_wdata, mc_addr); end
    mc_done = 1; mc_rdata = 32'h12345678;
    tick();
    mc_done = 0; lsu_req = 0; lsu_rw = 0;
    checks++; if (lsu_ack !== 1'b1 || lsu_rdata !== 32'h00000078) begin errors++; $display("FAIL store_ack: got ack %b data %h expected 1 00000078", lsu_ack, lsu_rdata); end
    tick();
    $display("txn lsu_store: addr 00030004 wdata 000000ab ack seen");
  endtask

  task automatic test_pf_then_if();
    pf_req = 1; pf_addr = 32'h5000;
    tick();
    checks++; if (mc_valid !== 1'b1 || mc_addr !== 32'h5000 || mc_type !== 2'b11) begin errors++; $display("FAIL pf_grant: got valid %b addr %h type %b expected 1 00005000 11", mc_valid, mc_addr, mc_type); end
    if_req = 1; if_addr = 32'h2040;
    tick();
    mc_done = 1; mc_rdata = 32'hA5A5A5A5;
    tick();
    mc_done = 0; pf_req = 0;
    checks++; if (pf_ack !== 1'b1 || pf_data !== 32'hA5A5A5A5 || if_ack !== 1'b0 || mc_valid !== 1'b0) begin errors++; $display("FAIL pf_ack: got pf %b data %h if %b valid %b expected 1 a5a5a5a5 0 0", pf_ack, pf_data, if_ack, mc_valid); end
    tick();
    checks++; if (mc_valid !== 1'b1 || mc_addr !== 32'h2040 || pf_ack !== 1'b0) begin errors++; $display("FAIL pf_then_if_grant: got valid %b addr %h pf %b expected 1 00002040 0", mc_valid, mc_addr, pf_ack); end
    mc_done = 1; mc_rdata = 32'h13579BDF;
    tick();
    mc_done = 0; if_req = 0;
    checks++; if (if_ack !== 1'b1 || if_data !== 32'h13579BDF || pf_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL pf_then_if_ack: got ack %b data %h pf_data %h expected 1 13579bdf a5a5a5a5", if_ack, if_data, pf_data); end
    tick();
    $display("txn pf_then_if: pf %h if %h", pf_data, if_data);
  endtask

  task automatic test_reset_mid_busy();
    lsu_req = 1; lsu_rw = 1; lsu_addr = 32'h7000; lsu_wdata = 32'h55; lsu_type = 2'b11;
    tick();
    checks++; if (mc_valid !== 1'b1 || mc_addr !== 32'h7000) begin errors++; $display("FAIL rst_busy_grant: got valid %b addr %h expected 1 00007000", mc_valid, mc_addr); end
    rst = 1;
    tick();
    rst = 0; lsu_req = 0; lsu_rw = 0;
    checks++; if ({mc_valid, mc_rw, mc_type} !== 4'b0 || mc_addr !== 32'h0 || mc_wdata !== 32'h0) begin errors++; $display("FAIL rst_busy_mc: got v%b rw%b t%b a %h wd %h expected all 0", mc_valid, mc_rw, mc_type, mc_addr, mc_wdata); end
    checks++; if (if_data !== 32'h0 || lsu_rdata !== 32'h0 || pf_data !== 32'h0) begin errors++; $display("FAIL rst_busy_data: got if %h lsu %h pf %h expected 0", if_data, lsu_rdata, pf_data); end
    tick();
    mc_done = 1; mc_rdata = 32'hCAFEF00D;
    tick();
    mc_done = 0;
    checks++; if ({if_ack, lsu_ack, pf_ack} !== 3'b000 || lsu_rdata !== 32'h0 || mc_valid !== 1'b0) begin errors++; $display("FAIL rst_late_done: got acks %b lsu %h valid %b expected 000 0 0", {if_ack, lsu_ack, pf_ack}, lsu_rdata, mc_valid); end
    tick();
    $display("txn reset_mid_busy: late mc_done ignored");
  endtask

  initial begin
    test_reset();
    test_lsu_read();
    test_starvation();
    test_flush_if();
    test_flush_blocks_idle();
    test_lsu_store_flush();
    test_pf_then_if();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
